// File: rtl/sha2_pkg.sv
// rtl/sha2_pkg.sv - SHA-2 constants, round helper functions and core state type
// Contents: K round constants, IV256/IV224 initial hash values,
//           ch/maj/big_sigma0/big_sigma1/small_sigma0/small_sigma1,
//           hv_t (eight 32-bit words, index 0 = a / H0 in the top bits),
//           state_e (IDLE, ROUND, FINAL, HOLD).
package sha2_pkg;

    typedef logic [0:7][31:0] hv_t;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, HOLD} state_e;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam hv_t IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam hv_t IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha2_stream_core_if.sv
// rtl/sha2_stream_core_if.sv - block input / digest output handshake bundle
// Signals: in_valid/in_ready/in_block/in_first/in_last/in_mode (block side),
//          out_valid/out_ready/out_digest/out_mode (digest side).
// master = block producer and digest consumer; slave = hashing core.
interface sha2_stream_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_block;
    logic         in_first;
    logic         in_last;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_digest;
    logic         out_mode;

    modport master (
        output in_valid, in_block, in_first, in_last, in_mode, out_ready,
        input  in_ready, out_valid, out_digest, out_mode
    );

    modport slave (
        input  in_valid, in_block, in_first, in_last, in_mode, out_ready,
        output in_ready, out_valid, out_digest, out_mode
    );
endinterface

// File: rtl/sha2_round.sv
// rtl/sha2_round.sv - one combinational SHA-2 compression round
// Ports: state_i (a..h in), k_i (round constant), w_i (schedule word),
//        state_o (a..h out).
module sha2_round
    import sha2_pkg::*;
(
    input  hv_t         state_i,
    input  logic [31:0] k_i,
    input  logic [31:0] w_i,
    output hv_t         state_o
);
    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1 = state_i[7] + big_sigma1(state_i[4]) + ch(state_i[4], state_i[5], state_i[6])
           + k_i + w_i;
        t2 = big_sigma0(state_i[0]) + maj(state_i[0], state_i[1], state_i[2]);
        state_o = {t1 + t2, state_i[0], state_i[1], state_i[2],
                   state_i[3] + t1, state_i[4], state_i[5], state_i[6]};
    end
endmodule

// File: rtl/sha2_stream_core.sv
// rtl/sha2_stream_core.sv - streaming SHA-256/SHA-224 core over pre-padded blocks
// Ports: clk, reset (sync, active-high); bus (slave side of sha2_stream_core_if);
//        busy (state != IDLE); seq_err (one-cycle pulse on orphan non-first block).
// Parameters: UNROLL rounds per clock (1, 2, 4); SUPPORT_224 enables in_mode.
module sha2_stream_core
    import sha2_pkg::*;
#(
    parameter int UNROLL      = 1,
    parameter bit SUPPORT_224 = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    sha2_stream_core_if.slave bus,
    output logic              busy,
    output logic              seq_err
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
        $error("sha2_stream_core: UNROLL must be 1, 2 or 4");
    end

    state_e       state_q;
    logic [31:0]  w_q [0:15];
    hv_t          wv_q;
    hv_t          h_q;
    logic [5:0]   cnt_q;
    logic         last_q;
    logic         mode_q;
    logic         open_q;
    logic         out_valid_q;
    logic [255:0] out_digest_q;
    logic         out_mode_q;
    logic         seq_err_q;

    logic         first_mode;
    hv_t          first_iv;
    hv_t          wv_d;
    hv_t          h_d;
    logic [31:0]  w_d [0:15];
    logic [31:0]  ext [0:19];

    assign first_mode = SUPPORT_224 ? bus.in_mode : 1'b0;
    assign first_iv   = first_mode ? IV224 : IV256;

    // Round chain: each stage feeds the next through its own generate scope.
    for (genvar i = 0; i < UNROLL; i++) begin : g_round
        hv_t st_in;
        hv_t st_out;
        if (i == 0) begin : g_head
            assign st_in = wv_q;
        end else begin : g_link
            assign st_in = g_round[i-1].st_out;
        end
        sha2_round u_round (
            .state_i (st_in),
            .k_i     (K[cnt_q + 6'(i)]),
            .w_i     (w_q[i]),
            .state_o (st_out)
        );
    end
    assign wv_d = g_round[UNROLL-1].st_out;

    // Schedule: ext[16+j] may depend on ext[16+j-2], so words are built in order.
    // Words generated past round 63 are never consumed.
    always_comb begin
        for (int k = 0; k < 16; k++) ext[k] = w_q[k];
        for (int k = 16; k < 20; k++) ext[k] = '0;
        for (int j = 0; j < UNROLL; j++) begin
            ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
        end
        for (int k = 0; k < 16; k++) w_d[k] = ext[k+UNROLL];
    end

    always_comb begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wv_q[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            for (int k = 0; k < 16; k++) w_q[k] <= '0;
            wv_q         <= '0;
            h_q          <= '0;
            cnt_q        <= '0;
            last_q       <= 1'b0;
            mode_q       <= 1'b0;
            open_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_digest_q <= '0;
            out_mode_q   <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            seq_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int k = 0; k < 16; k++) w_q[k] <= bus.in_block[511-32*k -: 32];
                        last_q  <= bus.in_last;
                        cnt_q   <= '0;
                        state_q <= ROUND;
                        if (bus.in_first) begin
                            mode_q <= first_mode;
                            h_q    <= first_iv;
                            wv_q   <= first_iv;
                            open_q <= 1'b1;
                        end else if (open_q) begin
                            wv_q <= h_q;
                        end else begin
                            // Orphan continuation: restart as a fresh SHA-256 message.
                            mode_q    <= 1'b0;
                            h_q       <= IV256;
                            wv_q      <= IV256;
                            open_q    <= 1'b1;
                            seq_err_q <= 1'b1;
                        end
                    end
                end
                ROUND: begin
                    wv_q <= wv_d;
                    for (int k = 0; k < 16; k++) w_q[k] <= w_d[k];
                    cnt_q <= cnt_q + 6'(UNROLL);
                    if (cnt_q == 6'(64 - UNROLL)) state_q <= FINAL;
                end
                FINAL: begin
                    h_q <= h_d;
                    if (last_q) begin
                        out_digest_q <= mode_q ? {h_d[0:6], 32'h0} : h_d;
                        out_mode_q   <= mode_q;
                        out_valid_q  <= 1'b1;
                        open_q       <= 1'b0;
                        state_q      <= HOLD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_digest = out_digest_q;
    assign bus.out_mode   = out_mode_q;
    assign busy           = (state_q != IDLE);
    assign seq_err        = seq_err_q;

endmodule
